// File: rtl/control_seq_if.sv
// Signal bundle between the control sequencer and the ROM/PC/datapath it drives.
// The master side is the sequencer; the slave side is the ROM, PC and datapath.
interface control_seq_if #(
    parameter int SEL_W = 3
);
    localparam int NSEL = 2**SEL_W;
    localparam int IR_W = 2*SEL_W + 2;

    logic [IR_W-1:0] irIn;
    logic            romReady;
    logic            aIsZero;
    logic            aluCarry;
    logic            aluShift;
    logic            resume;

    logic [NSEL-1:0] load;
    logic [NSEL-1:0] assertBar;
    logic            irLoad;
    logic            pcInc;
    logic            pcLoad;
    logic            doSubtract;
    logic            doShiftIn;
    logic            doCarryIn;
    logic            flagCarry;
    logic            flagShift;
    logic            halted;

    modport master (
        input  irIn, romReady, aIsZero, aluCarry, aluShift, resume,
        output load, assertBar, irLoad, pcInc, pcLoad,
               doSubtract, doShiftIn, doCarryIn, flagCarry, flagShift, halted
    );

    modport slave (
        output irIn, romReady, aIsZero, aluCarry, aluShift, resume,
        input  load, assertBar, irLoad, pcInc, pcLoad,
               doSubtract, doShiftIn, doCarryIn, flagCarry, flagShift, halted
    );
endinterface

// File: rtl/control_seq.sv
// FETCH/EXEC/HALT control sequencer: latches an opcode from ROM, then drives
// one-hot load strobes and active-low bus enables for one execute cycle.
module control_seq #(
    parameter int SEL_W   = 3,
    parameter int SRC_ROM = 1,
    parameter int SRC_ALU = 6,
    parameter int SRC_SHF = (2**SEL_W) - 1,
    parameter int DST_PC  = (2**SEL_W) - 1
) (
    input  logic          clk,
    input  logic          resetBar,
    control_seq_if.master bus
);
    localparam int NSEL = 2**SEL_W;
    localparam int IR_W = 2*SEL_W + 2;

    localparam logic [SEL_W-1:0] SRC_ROM_S = SEL_W'(SRC_ROM);
    localparam logic [SEL_W-1:0] SRC_ALU_S = SEL_W'(SRC_ALU);
    localparam logic [SEL_W-1:0] SRC_SHF_S = SEL_W'(SRC_SHF);
    localparam logic [SEL_W-1:0] DST_PC_S  = SEL_W'(DST_PC);
    localparam logic [SEL_W-1:0] DST_SINKS = SEL_W'(2);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seqState_t;

    seqState_t       stateReg, stateNext;
    logic [IR_W-1:0] irReg, irNext;
    logic            flagCarryReg, flagCarryNext;
    logic            flagShiftReg, flagShiftNext;

    logic             bitHi, bitLo;
    logic [SEL_W-1:0] srcSel, dstSel;
    logic             isNop, srcIsRom, dstIsPc, stall, jumpTaken;

    logic loadEn, assertEn;
    logic irLoadC, pcIncC, pcLoadC, doLoC, doHiC, haltedC;

    // Opcode layout: {bitHi, dest, bitLo, source}
    assign bitHi  = irReg[IR_W-1];
    assign dstSel = irReg[IR_W-2 -: SEL_W];
    assign bitLo  = irReg[SEL_W];
    assign srcSel = irReg[SEL_W-1:0];

    assign isNop    = (irReg == '0);
    assign srcIsRom = (srcSel == SRC_ROM_S);
    assign dstIsPc  = (dstSel == DST_PC_S);
    assign stall    = (stateReg == EXEC) && srcIsRom && !bus.romReady;

    always_comb begin
        jumpTaken = 1'b1;
        unique case ({bitHi, bitLo})
            2'b00:   jumpTaken = 1'b1;
            2'b01:   jumpTaken = bus.aIsZero;
            2'b10:   jumpTaken = flagCarryReg;
            default: jumpTaken = flagShiftReg;
        endcase
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            stateReg     <= FETCH;
            irReg        <= '0;
            flagCarryReg <= 1'b0;
            flagShiftReg <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            irReg        <= irNext;
            flagCarryReg <= flagCarryNext;
            flagShiftReg <= flagShiftNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        irNext        = irReg;
        flagCarryNext = flagCarryReg;
        flagShiftNext = flagShiftReg;
        case (stateReg)
            FETCH: begin
                if (bus.romReady) begin
                    irNext    = bus.irIn;
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    stateNext = isNop ? HALT : FETCH;
                    if (!isNop) begin
                        if (srcSel == SRC_ALU_S) flagCarryNext = bus.aluCarry;
                        if (srcSel == SRC_SHF_S) flagShiftNext = bus.aluShift;
                    end
                end
            end
            HALT: begin
                if (bus.resume) stateNext = FETCH;
            end
            default: stateNext = FETCH;
        endcase
    end

    // Everything is gated by resetBar so an asserted reset silences the bus at once.
    always_comb begin
        loadEn   = 1'b0;
        assertEn = 1'b0;
        irLoadC  = 1'b0;
        pcIncC   = 1'b0;
        pcLoadC  = 1'b0;
        doLoC    = 1'b0;
        doHiC    = 1'b0;
        haltedC  = 1'b0;
        if (resetBar) begin
            case (stateReg)
                FETCH: begin
                    irLoadC = 1'b1;
                    pcIncC  = bus.romReady;
                end
                EXEC: begin
                    if (stall) begin
                        assertEn = 1'b1;
                    end else if (!isNop) begin
                        assertEn = 1'b1;
                        doLoC    = bitLo;
                        doHiC    = bitHi;
                        if (dstIsPc) begin
                            // Untaken jump with an immediate still steps past the operand.
                            pcLoadC = jumpTaken;
                            loadEn  = jumpTaken;
                            pcIncC  = !jumpTaken && srcIsRom;
                        end else begin
                            loadEn = (dstSel >= DST_SINKS);
                            pcIncC = srcIsRom;
                        end
                    end
                end
                HALT: begin
                    haltedC = 1'b1;
                end
                default: begin
                    haltedC = 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : gSlot
            assign bus.load[gi]      = loadEn && (dstSel == SEL_W'(gi));
            assign bus.assertBar[gi] = ~(assertEn && (srcSel == SEL_W'(gi)));
        end
    endgenerate

    assign bus.irLoad     = irLoadC;
    assign bus.pcInc      = pcIncC;
    assign bus.pcLoad     = pcLoadC;
    assign bus.doSubtract = doLoC;
    assign bus.doShiftIn  = doLoC;
    assign bus.doCarryIn  = doHiC;
    assign bus.flagCarry  = flagCarryReg;
    assign bus.flagShift  = flagShiftReg;
    assign bus.halted     = haltedC;
endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised successor to the nic8 single-cycle control decoder.
- Adds an explicit FETCH/EXEC/HALT sequencer, an internal instruction register and registered carry/shift flags.
- Adds ROM wait-state stalling, a halt/resume mode, and source/dest select fields whose width is set by parameter.
- Sits between the program ROM/PC and the datapath, and drives one-hot register-load strobes and active-low bus-assert enables.

Parameters:
- SEL_W, 3: width of the source and dest fields. The number of bus slots is NSEL = 2**SEL_W. The instruction width is IR_W = 2*SEL_W+2, derived and not overridable.
- SRC_ROM, 1: source index meaning "immediate operand from ROM".
- SRC_ALU, 6: source index of the adder (E). Selecting it updates flagCarry.
- SRC_SHF, NSEL-1: source index of the shifter (S). Selecting it updates flagShift.
- DST_PC, NSEL-1: dest index meaning "load PC", which is a jump.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetBar  in  1  asynchronous active-low reset.
- irIn  in  IR_W  ROM data bus, laid out as {bitHi, dest[SEL_W], bitLo, source[SEL_W]}.
- romReady  in  1  ROM data valid this cycle; 0 inserts a wait state.
- aIsZero  in  1  live A==0 indication from the datapath.
- aluCarry  in  1  adder carry-out.
- aluShift  in  1  shifter bit-out.
- resume  in  1  leave HALT.
- load  out  NSEL  one-hot active-high register-capture strobe, indexed by dest.
- assertBar  out  NSEL  one-hot active-low bus-drive enable, indexed by source.
- irLoad  out  1  ROM is driving an opcode (FETCH).
- pcInc  out  1  PC increments at the end of this cycle.
- pcLoad  out  1  PC loads from the bus at the end of this cycle.
- doSubtract, doShiftIn  out  1  equal to bitLo of ir during EXEC, 0 otherwise.
- doCarryIn  out  1  equal to bitHi of ir during EXEC, 0 otherwise.
- flagCarry, flagShift  out  1  registered flags.
- halted  out  1  state==HALT.

Behaviour:
Reset:
- While resetBar=0: state=FETCH, ir=0, flagCarry=flagShift=0.
- All outputs inactive while resetBar=0: load=0, assertBar=all-ones, irLoad=pcInc=pcLoad=0, do*=0, halted=0.
- Reset asserted mid-EXEC kills the strobes immediately, with no partial capture.

Output timing:
- All strobes are combinational from (state, ir, romReady, flags, aIsZero).
- Datapath registers capture on the rising edge that ends a cycle in which their load bit is 1.

FETCH:
- irLoad=1; assertBar all-ones; load=0.
- If romReady=1: ir<=irIn, pcInc=1, next state EXEC.
- If romReady=0: hold, pcInc=0.

EXEC: decode ir.
- assertBar[source]=0. Any source==SRC_ROM operand also requires romReady.
- Stall: when source==SRC_ROM and romReady=0, every strobe is 0 except assertBar[SRC_ROM], and the state holds.
- Jump condition, taken from {bitHi,bitLo}:
  - 00: always.
  - 01: aIsZero.
  - 10: flagCarry.
  - 11: flagShift.
- dest==DST_PC:
  - If the condition is true: pcLoad=1, pcInc=0.
  - Otherwise: pcLoad=0, and pcInc=(source==SRC_ROM) so the operand is skipped.
  - load[DST_PC] mirrors pcLoad.
- Other dest: load[dest]=1, and pcInc=(source==SRC_ROM).
- Dest 0 and dest 1 never assert load; they are no-op sinks.
- Flags:
  - source==SRC_ALU: flagCarry<=aluCarry at the end of EXEC.
  - source==SRC_SHF: flagShift<=aluShift.
  - Otherwise the flags hold.
  - Flags read by a jump are the pre-update values.
- Next state: ir==0 goes to HALT, otherwise FETCH.
- ir==0 performs no load, no PC change and no flag change.

HALT:
- All strobes inactive; halted=1.
- resume=1 sampled at an edge goes to FETCH, continuing at the current PC.

Timing:
- Instruction latency is 2 cycles plus ROM wait states.
- pcInc and pcLoad are never both 1.
- At most one load bit is set, and at most one assertBar bit is low.

Test Plan:
1. Reset mid-EXEC of ir=0x21: while resetBar=0, load=0 and assertBar=0xFF. After release, first cycle irLoad=1, flags=0.
2. ROM 0x21,0x05 with romReady=1 → FETCH (irLoad, pcInc), then EXEC with assertBar=0xFD, load=0x04, pcInc=1. PC advanced by 2 over 2 cycles.
3. Same as scenario 2 but romReady=0 for 2 cycles during EXEC → load stays 0 and the state holds. load=0x04 asserts only in the cycle romReady returns; 4 cycles total.
4. ir=0x26 with aluCarry=1 → load=0x04, assertBar=0xBF, doSubtract=0, flagCarry=1 afterwards. Then ir=0xF1 (jump-if-carry, immediate) → pcLoad=1, pcInc=0.
5. ir=0x79 with aIsZero=0 → pcLoad=0, pcInc=1 (operand skipped). Repeat with aIsZero=1 → pcLoad=1.
6. ir=0x00 → HALT, halted=1, strobes idle for 10 cycles. Pulse resume=1 → next cycle FETCH with irLoad=1. Rerun with SEL_W=4 (IR_W=10): load/assertBar are 16 bits wide and ir=0x3E1 jumps to immediate.
